nmos_dyn_node: RTL and testbench

NMOS_DYN_NODE -- requirements
Module: nmos_dyn_node

---
 rtl/nmos_dyn_node.sv | 100 ++++++++++
 tb/tb_nmos_dyn_node.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nmos_dyn_node.sv
// Behavioural model of a dynamic NMOS storage node driven by pass transistors
// and a precharge device; the charge leaks away after HOLD_CYC idle cycles.
module nmos_dyn_node #(
  parameter int unsigned N_DRV     = 4,
  parameter int unsigned HOLD_CYC  = 16,
  parameter logic        DECAY_VAL = 1'b0,
  localparam int unsigned AW       = (HOLD_CYC == 0) ? 1 : $clog2(HOLD_CYC + 1)
) (
  input  logic             main_clk,
  input  logic             rst_n,
  input  logic             PCH,
  input  logic [N_DRV-1:0] G,
  input  logic [N_DRV-1:0] D,
  input  logic             CONT_CLR,
  output logic             Q,
  output logic             VALID,
  output logic             CONTENT,
  output logic [AW-1:0]    AGE
);

  typedef enum logic [1:0] {StDecayed, StPrech, StDriven, StHold} state_e;

  localparam logic [AW-1:0] HoldAge = AW'(HOLD_CYC);

  state_e        state_q, state_d;
  logic          q_q, q_d;
  logic          valid_q, valid_d;
  logic          cont_q, cont_d;
  logic [AW-1:0] age_q, age_d;

  logic          any_g;
  logic          pull_low;
  logic          pull_high;
  logic          contend;
  logic [AW-1:0] age_inc;

  assign any_g     = |G;
  assign pull_low  = |(G & ~D);
  assign pull_high = |(G & D);
  // Under precharge only a driver pulling low fights the node; otherwise any disagreement does.
  assign contend   = PCH ? pull_low : (pull_high & pull_low);
  assign age_inc   = age_q + AW'(1);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    age_d   = age_q;
    if (PCH) begin
      state_d = StPrech;
      q_d     = 1'b1;
      age_d   = '0;
    end else if (any_g) begin
      state_d = StDriven;
      q_d     = ~pull_low;  // low dominates on disagreement
      age_d   = '0;
    end else if (state_q != StDecayed) begin
      if (HOLD_CYC == 0) begin
        state_d = StHold;
      end else if (age_inc == HoldAge) begin
        state_d = StDecayed;
        q_d     = DECAY_VAL;
        age_d   = age_inc;
      end else begin
        state_d = StHold;
        age_d   = age_inc;
      end
    end
    // A floating decayed node keeps its age: 0 after reset, HOLD_CYC after a leak.
    valid_d = (state_d != StDecayed);
    if (contend) begin
      cont_d = 1'b1;
    end else if (CONT_CLR) begin
      cont_d = 1'b0;
    end else begin
      cont_d = cont_q;
    end
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StDecayed;
      q_q     <= DECAY_VAL;
      valid_q <= 1'b0;
      cont_q  <= 1'b0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      cont_q  <= cont_d;
      age_q   <= age_d;
    end
  end

  assign Q       = q_q;
  assign VALID   = valid_q;
  assign CONTENT = cont_q;
  assign AGE     = age_q;

endmodule

// File: tb/tb_nmos_dyn_node.sv
// Bench for nmos_dyn_node: a finite-retention node and an infinite-retention
// node share stimulus and are checked against a time-stamp model every cycle.
module tb_nmos_dyn_node;

  logic       main_clk = 1'b0;
  logic       rst_n;
  logic       PCH;
  logic [3:0] G;
  logic [3:0] D;
  logic       CONT_CLR;

  logic       q4, v4, c4;
  logic [2:0] a4;
  logic       q0, v0, c0;
  logic [0:0] a0;

  nmos_dyn_node #(.N_DRV(4), .HOLD_CYC(4), .DECAY_VAL(1'b0)) dut4 (
    .main_clk(main_clk), .rst_n(rst_n), .PCH(PCH), .G(G), .D(D), .CONT_CLR(CONT_CLR),
    .Q(q4), .VALID(v4), .CONTENT(c4), .AGE(a4)
  );

  nmos_dyn_node #(.N_DRV(4), .HOLD_CYC(0), .DECAY_VAL(1'b0)) dut0 (
    .main_clk(main_clk), .rst_n(rst_n), .PCH(PCH), .G(G), .D(D), .CONT_CLR(CONT_CLR),
    .Q(q0), .VALID(v0), .CONTENT(c0), .AGE(a0)
  );

  always #5 main_clk = ~main_clk;

  int checks = 0;
  int errs   = 0;

  // Model: a node is either uncharged since reset, or holds a value stamped with the
  // edge index of its last drive; age and leakage follow from the elapsed edge count.
  int cyc = 0;
  bit m_ch   [2];
  bit m_val  [2];
  bit m_cont [2];
  int m_last [2];
  int hold   [2] = '{4, 0};

  // Literal expectations posted by the stimulus, checked at the next falling edge.
  int    lit_seq = 0;
  int    lit_k;
  string lit_name;
  bit    lit_q, lit_v, lit_c;
  int    lit_age;

  task automatic expect_lit(input string n, input int k, input bit q, input bit v, input bit c,
                            input int age);
    lit_name = n;
    lit_k    = k;
    lit_q    = q;
    lit_v    = v;
    lit_c    = c;
    lit_age  = age;
    lit_seq++;
  endtask

  function automatic void exp_out(input int k, output bit q, output bit v, output int age);
    int e;
    if (!m_ch[k]) begin
      q = 1'b0; v = 1'b0; age = 0;
    end else if (hold[k] == 0) begin
      q = m_val[k]; v = 1'b1; age = 0;
    end else begin
      e   = cyc - m_last[k];
      v   = (e < hold[k]);
      age = v ? e : hold[k];
      q   = v ? m_val[k] : 1'b0;
    end
  endfunction

  task automatic model_edge();
    bit low, high, clash;
    low   = |(G & ~D);
    high  = |(G & D);
    clash = PCH ? low : (low && high);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (PCH) begin
        m_ch[k] = 1'b1; m_val[k] = 1'b1; m_last[k] = cyc;
      end else if (G != 4'b0) begin
        m_ch[k] = 1'b1; m_val[k] = !low; m_last[k] = cyc;
      end
      if (clash) m_cont[k] = 1'b1;
      else if (CONT_CLR) m_cont[k] = 1'b0;
    end
  endtask

  task automatic step(input bit pch, input logic [3:0] g, input logic [3:0] d, input bit clr);
    PCH = pch; G = g; D = d; CONT_CLR = clr;
    @(posedge main_clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ch[k] = 1'b0; m_cont[k] = 1'b0;
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endtask

  initial begin : compare
    int seen = 0;
    forever begin
      bit eq, ev;
      int ea;
      @(negedge main_clk);
      for (int k = 0; k < 2; k++) begin
        exp_out(k, eq, ev, ea);
        chk($sformatf("Q[h%0d]", hold[k]),       k == 0 ? int'(q4) : int'(q0), int'(eq));
        chk($sformatf("VALID[h%0d]", hold[k]),   k == 0 ? int'(v4) : int'(v0), int'(ev));
        chk($sformatf("CONTENT[h%0d]", hold[k]), k == 0 ? int'(c4) : int'(c0), int'(m_cont[k]));
        chk($sformatf("AGE[h%0d]", hold[k]),     k == 0 ? int'(a4) : int'(a0), ea);
      end
      if (lit_seq != seen) begin
        seen = lit_seq;
        chk({lit_name, ".Q"},       lit_k == 0 ? int'(q4) : int'(q0), int'(lit_q));
        chk({lit_name, ".VALID"},   lit_k == 0 ? int'(v4) : int'(v0), int'(lit_v));
        chk({lit_name, ".CONTENT"}, lit_k == 0 ? int'(c4) : int'(c0), int'(lit_c));
        chk({lit_name, ".AGE"},     lit_k == 0 ? int'(a4) : int'(a0), lit_age);
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; PCH = 1'b0; G = '0; D = '0; CONT_CLR = 1'b0;
    expect_lit("reset", 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;

    // Uncharged after reset: no ageing while floating.
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0);
    expect_lit("idle_after_reset", 0, 0, 0, 0, 0);

    // Precharge then leak after four idle edges.
    step(1, 4'b0000, 4'b0000, 0); expect_lit("pch", 0, 1, 1, 0, 0);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("hold1", 0, 1, 1, 0, 1);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("hold2", 0, 1, 1, 0, 2);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("hold3", 0, 1, 1, 0, 3);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("decay", 0, 0, 0, 0, 4);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("decay_sat", 0, 0, 0, 0, 4);

    // Agreeing drivers, disagreeing drivers, then clear.
    step(0, 4'b0011, 4'b0011, 0); expect_lit("agree", 0, 1, 1, 0, 0);
    step(0, 4'b0101, 4'b0001, 0); expect_lit("clash", 0, 0, 1, 1, 0);
    step(0, 4'b0000, 4'b0000, 1); expect_lit("clr", 0, 0, 1, 0, 1);

    // Drive on the edge that would otherwise decay.
    step(0, 4'b0010, 4'b0010, 0);
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("pre_rescue", 0, 1, 1, 0, 3);
    step(0, 4'b0100, 4'b0100, 0); expect_lit("rescue", 0, 1, 1, 0, 0);

    // Precharge fighting a low driver; contention beats a same-edge clear.
    step(1, 4'b0001, 4'b0000, 0); expect_lit("pch_fight", 0, 1, 1, 1, 0);
    step(1, 4'b0001, 4'b0000, 1); expect_lit("clr_vs_clash", 0, 1, 1, 1, 0);
    step(0, 4'b0000, 4'b0000, 1); expect_lit("clr2", 0, 1, 1, 0, 1);
    step(0, 4'b1000, 4'b1000, 1); expect_lit("pch_hi_drv", 0, 1, 1, 0, 0);

    // Asynchronous reset between edges while holding a 1.
    step(0, 4'b0000, 4'b0000, 0);
    step(1, 4'b0001, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0);
    pulse_reset();
    expect_lit("reset_mid_hold", 0, 0, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 0); expect_lit("post_reset_idle", 0, 0, 0, 0, 0);

    // Infinite retention.
    step(0, 4'b0001, 4'b0001, 0);
    for (int i = 0; i < 1000; i++) step(0, 4'b0000, 4'b0000, 0);
    expect_lit("infinite_hold", 1, 1, 1, 0, 0);

    @(negedge main_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
